// File: rtl/t5_dmem.sv
// ---------------------------------------------------------------------------
// t5_dmem : single-port data memory with a Wishbone-style handshake towards
//           the core. Every transfer is stretched by WAIT wait cycles before
//           its one-cycle completion pulse.
//
// Parameters
//   AW    word-address width, depth is 2**AW 32-bit words (AW < 30)
//   WAIT  wait cycles inserted before completion, 0..15
//
// Ports
//   sys_clk   in   1   clock, all state changes on the rising edge
//   sys_rst   in   1   synchronous active-low reset
//   sys_ena   in   1   clock enable, low freezes all state and outputs
//   dwb_adr   in  30   word address (byte address bits [31:2])
//   dwb_dto   in  32   write data
//   dwb_sel   in   4   byte-lane select
//   dwb_stb   in   1   transfer request
//   dwb_wre   in   1   1 = write, 0 = read
//   dwb_dti   out 32   registered read data
//   dwb_ack   out  1   registered completion pulse
//   dwb_err   out  1   registered error pulse for an illegal select
//
// Build option
//   T5_DMEM_ERR_EN  when defined, an illegal select completes with dwb_err
//                   instead of dwb_ack; when undefined dwb_err is tied low.
// ---------------------------------------------------------------------------
module t5_dmem #(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sys_ena,
    input  logic [29:0] dwb_adr,
    input  logic [31:0] dwb_dto,
    input  logic [3:0]  dwb_sel,
    input  logic        dwb_stb,
    input  logic        dwb_wre,
    output logic [31:0] dwb_dti,
    output logic        dwb_ack,
    output logic        dwb_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [31:0]   mem [2**AW];

    logic [1:0]    state;
    logic [3:0]    count;

    logic [AW-1:0] lat_adr;
    logic [31:0]   lat_dto;
    logic [3:0]    lat_sel;
    logic          lat_wre;

    logic [AW-1:0] op_adr;
    logic [31:0]   op_dto;
    logic [3:0]    op_sel;
    logic          op_wre;
    logic          sel_legal;
    logic          enter_done;
    logic          commit_write;

    // Upper address bits alias away by design.
    logic          unused_adr;
    assign unused_adr = ^dwb_adr[29:AW];

    // With WAIT=0 the transfer completes on its sampling edge, so the live
    // request fields must be used there; otherwise the captured copy is used.
    always_comb begin
        op_adr = lat_adr;
        op_dto = lat_dto;
        op_sel = lat_sel;
        op_wre = lat_wre;
        if (state == ST_IDLE) begin
            op_adr = dwb_adr[AW-1:0];
            op_dto = dwb_dto;
            op_sel = dwb_sel;
            op_wre = dwb_wre;
        end
    end

    always_comb begin
        sel_legal = 1'b0;
        case (op_sel)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end

    // Marks the edge on which the FSM moves into DONE.
    always_comb begin
        enter_done = 1'b0;
        if (sys_ena && dwb_stb) begin
            if (state == ST_IDLE && WAIT_CNT == 4'd0)
                enter_done = 1'b1;
            else if (state == ST_WAIT && count == 4'd1)
                enter_done = 1'b1;
        end
    end

    // A reset on the completing edge must still suppress the write.
    assign commit_write = sys_rst && enter_done && op_wre && sel_legal;

    always_ff @(posedge sys_clk) begin
        if (commit_write) begin
            for (int b = 0; b < 4; b++) begin
                if (op_sel[b])
                    mem[op_adr][8*b +: 8] <= op_dto[8*b +: 8];
            end
        end
    end

`ifdef T5_DMEM_ERR_EN
    logic err_q;
    assign dwb_err = err_q;
`else
    assign dwb_err = 1'b0;
`endif

    // Pulses clear every enabled cycle, so with sys_ena low in DONE they
    // stay high until the enable returns.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state   <= ST_IDLE;
            count   <= 4'd0;
            dwb_ack <= 1'b0;
            dwb_dti <= 32'd0;
`ifdef T5_DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else if (sys_ena) begin
            dwb_ack <= 1'b0;
`ifdef T5_DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (dwb_stb) begin
                        lat_adr <= dwb_adr[AW-1:0];
                        lat_dto <= dwb_dto;
                        lat_sel <= dwb_sel;
                        lat_wre <= dwb_wre;
                        if (WAIT_CNT == 4'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            count <= WAIT_CNT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!dwb_stb) begin
                        state <= ST_IDLE;
                        count <= 4'd0;
                    end else if (count == 4'd1) begin
                        state <= ST_DONE;
                        count <= 4'd0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    count <= 4'd0;
                end
            endcase

            if (enter_done) begin
                if (sel_legal) begin
                    dwb_ack <= 1'b1;
                    if (!op_wre)
                        dwb_dti <= mem[op_adr];
                end else begin
                    dwb_dti <= 32'd0;
`ifdef T5_DMEM_ERR_EN
                    err_q   <= 1'b1;
`else
                    dwb_ack <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_t5_dmem.sv
// ---------------------------------------------------------------------------
// tb_t5_dmem : directed self-checking bench for t5_dmem.
// Instance A uses WAIT=1, instance B uses WAIT=3; both AW=10 and share all
// inputs except their request strobes.
// ---------------------------------------------------------------------------
module tb_t5_dmem;

`ifdef T5_DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        sys_ena;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_wre;
    logic        stb_a;
    logic        stb_b;
    logic [31:0] dti_a, dti_b;
    logic        ack_a, ack_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    t5_dmem #(.AW(10), .WAIT(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ena(sys_ena),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_stb(stb_a), .dwb_wre(dwb_wre),
        .dwb_dti(dti_a), .dwb_ack(ack_a), .dwb_err(err_a)
    );

    t5_dmem #(.AW(10), .WAIT(3)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ena(sys_ena),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_stb(stb_b), .dwb_wre(dwb_wre),
        .dwb_dti(dti_b), .dwb_ack(ack_b), .dwb_err(err_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One complete transfer; request fields are scrambled right after the
    // sampling edge so any use of live inputs shows up.
    task automatic applyStimulus(input bit use_b, input logic wre,
                                 input logic [29:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dto, input bit illegal,
                                 input bit chk_dti, input logic [31:0] exp_dti);
        int lat;
        lat = use_b ? 3 : 1;
        dwb_wre = wre;
        dwb_adr = adr;
        dwb_sel = sel;
        dwb_dto = dto;
        if (use_b) stb_b = 1'b1; else stb_a = 1'b1;
        step();
        dwb_wre = ~wre;
        dwb_adr = ~adr;
        dwb_sel = 4'hF;
        dwb_dto = ~dto;
        for (int i = 0; i < lat; i++) begin
            checkOutput("wait_ack", use_b ? ack_b : ack_a, 32'd0);
            checkOutput("wait_err", use_b ? err_b : err_a, 32'd0);
            step();
        end
        checkOutput("done_ack", use_b ? ack_b : ack_a,
                    illegal ? 32'(!ERR_EN) : 32'd1);
        checkOutput("done_err", use_b ? err_b : err_a,
                    illegal ? 32'(ERR_EN) : 32'd0);
        if (chk_dti)
            checkOutput("done_dti", use_b ? dti_b : dti_a, exp_dti);
        stb_a = 1'b0;
        stb_b = 1'b0;
        step();
        checkOutput("idle_ack", use_b ? ack_b : ack_a, 32'd0);
        checkOutput("idle_err", use_b ? err_b : err_a, 32'd0);
    endtask

    initial begin
        logic [4:0] held_pat;
        sys_rst = 1'b0;
        sys_ena = 1'b1;
        stb_a   = 1'b0;
        stb_b   = 1'b0;
        dwb_adr = '0;
        dwb_dto = '0;
        dwb_sel = '0;
        dwb_wre = 1'b0;
        step();
        step();
        checkOutput("rst_ack_a", ack_a, 32'd0);
        checkOutput("rst_err_a", err_a, 32'd0);
        checkOutput("rst_dti_a", dti_a, 32'd0);
        checkOutput("rst_ack_b", ack_b, 32'd0);
        checkOutput("rst_dti_b", dti_b, 32'd0);
        sys_rst = 1'b1;
        step();

        // Basic write/read
        applyStimulus(0, 1, 30'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        applyStimulus(0, 0, 30'h10, 4'hF, 32'h0, 0, 1, 32'hDEADBEEF);

        // Byte-lane writes
        applyStimulus(0, 1, 30'h20, 4'hF, 32'h11223344, 0, 0, 0);
        applyStimulus(0, 1, 30'h20, 4'h2, 32'h0000AA00, 0, 0, 0);
        applyStimulus(0, 0, 30'h20, 4'hF, 32'h0, 0, 1, 32'h1122AA44);
        applyStimulus(0, 1, 30'h20, 4'hF, 32'h11223344, 0, 0, 0);
        applyStimulus(0, 1, 30'h20, 4'hC, 32'h55660000, 0, 0, 0);
        applyStimulus(0, 0, 30'h20, 4'hF, 32'h0, 0, 1, 32'h55663344);
        applyStimulus(0, 0, 30'h20, 4'h1, 32'h0, 0, 1, 32'h55663344);

        // Illegal selects: no write, dti forced to zero
        applyStimulus(0, 1, 30'h20, 4'h5, 32'hFFFFFFFF, 1, 1, 32'h0);
        applyStimulus(0, 0, 30'h20, 4'hF, 32'h0, 0, 1, 32'h55663344);
        applyStimulus(0, 0, 30'h20, 4'h0, 32'h0, 1, 1, 32'h0);

        // Address aliasing modulo 1024 words
        applyStimulus(0, 1, 30'h400, 4'hF, 32'h00000001, 0, 0, 0);
        applyStimulus(0, 0, 30'h000, 4'hF, 32'h0, 0, 1, 32'h00000001);

        // Held strobe: completions every WAIT+2 = 3 cycles
        dwb_wre = 1'b0;
        dwb_adr = 30'h10;
        dwb_sel = 4'hF;
        stb_a   = 1'b1;
        held_pat = 5'b10010;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("held_ack", ack_a, 32'(held_pat[i]));
        end
        stb_a = 1'b0;
        checkOutput("held_dti", dti_a, 32'hDEADBEEF);
        step();
        checkOutput("held_end_ack", ack_a, 32'd0);

        // Enable low while in DONE stretches the pulse
        applyStimulus(0, 0, 30'h000, 4'hF, 32'h0, 0, 1, 32'h00000001);
        dwb_adr = 30'h10;
        dwb_sel = 4'hF;
        dwb_wre = 1'b0;
        stb_a   = 1'b1;
        step();
        step();
        checkOutput("ena_done_ack", ack_a, 32'd1);
        checkOutput("ena_done_dti", dti_a, 32'hDEADBEEF);
        stb_a   = 1'b0;
        sys_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("ena_hold_ack", ack_a, 32'd1);
        end
        sys_ena = 1'b1;
        step();
        checkOutput("ena_release_ack", ack_a, 32'd0);
        step();
        checkOutput("ena_single_ack", ack_a, 32'd0);

        // Reset in WAIT, coinciding with DONE entry: write is dropped
        applyStimulus(0, 1, 30'h30, 4'hF, 32'h12345678, 0, 0, 0);
        applyStimulus(0, 0, 30'h30, 4'hF, 32'h0, 0, 1, 32'h12345678);
        dwb_adr = 30'h30;
        dwb_sel = 4'hF;
        dwb_dto = 32'hCAFEF00D;
        dwb_wre = 1'b1;
        stb_a   = 1'b1;
        step();
        sys_rst = 1'b0;
        step();
        checkOutput("wrst_ack", ack_a, 32'd0);
        checkOutput("wrst_err", err_a, 32'd0);
        checkOutput("wrst_dti", dti_a, 32'd0);
        sys_rst = 1'b1;
        stb_a   = 1'b0;
        step();
        checkOutput("wrst_idle_ack", ack_a, 32'd0);
        applyStimulus(0, 0, 30'h30, 4'hF, 32'h0, 0, 1, 32'h12345678);

        // Reset overrides a low enable
        sys_ena = 1'b0;
        sys_rst = 1'b0;
        step();
        checkOutput("rst_over_ena_dti", dti_a, 32'd0);
        sys_ena = 1'b1;
        sys_rst = 1'b1;
        step();

        // WAIT=3 instance: full latency, then an aborted write
        applyStimulus(1, 1, 30'h40, 4'hF, 32'hAAAA5555, 0, 0, 0);
        applyStimulus(1, 0, 30'h40, 4'hF, 32'h0, 0, 1, 32'hAAAA5555);
        dwb_adr = 30'h40;
        dwb_sel = 4'hF;
        dwb_dto = 32'h00000000;
        dwb_wre = 1'b1;
        stb_b   = 1'b1;
        step();
        step();
        stb_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("abort_ack", ack_b, 32'd0);
            checkOutput("abort_err", err_b, 32'd0);
        end
        applyStimulus(1, 0, 30'h40, 4'hF, 32'h0, 0, 1, 32'hAAAA5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
